// File: rtl/md_issue_ctrl.sv
// Issue gate and busy-window mirror between E-stage control and the multiply/divide unit.
// Optional stall-cycle counter enabled by defining MD_STALL_CNT_EN.
module md_issue_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        E_Valid,
  input  logic        E_Flush,
  input  logic [2:0]  E_MDOp,
  input  logic [31:0] E_Data2,
  input  logic        D_UseMD,
  input  logic        MDU_Busy,
  output logic [2:0]  MDOp,
  output logic        D_Stall,
  output logic        Done,
  output logic        Err,
  output logic [31:0] StallCnt
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              busy, issue_ok, is_mul, is_div, start;

  assign busy     = (state_q != StIdle);
  assign issue_ok = E_Valid & ~E_Flush & ~busy & Reset;
  assign is_mul   = (E_MDOp == 3'b001) | (E_MDOp == 3'b010) | (E_MDOp == 3'b111);
  // A zero divisor is passed through but opens no busy window.
  assign is_div   = ((E_MDOp == 3'b011) | (E_MDOp == 3'b100)) & (|E_Data2);
  assign start    = issue_ok & (is_mul | is_div);

  assign MDOp    = issue_ok ? E_MDOp : 3'b000;
  assign D_Stall = Reset & D_UseMD & (start | busy);
  assign Done    = Reset & busy & (cnt_q == CntW'(1));
  assign Err     = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = is_mul ? StMul : StDiv;
          cnt_d   = is_mul ? CntW'(MUL_LAT) : CntW'(DIV_LAT);
        end
      end
      StMul, StDiv: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Ops arriving while busy are dropped; MDU disagreement means the mirror is broken.
    if ((E_Valid && (E_MDOp != 3'b000) && busy) || (MDU_Busy != busy)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q <= 32'd0;
    end else if (D_Stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
`else
  assign StallCnt = 32'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios then randomized traffic
// against a cycle-count reference model; the bench also plays the MDU busy line.
module tb_md_issue_ctrl;

  localparam int MulLat = 5;
  localparam int DivLat = 10;

  logic        Clk = 1'b0;
  logic        Reset, E_Valid, E_Flush, D_UseMD, MDU_Busy;
  logic [2:0]  E_MDOp;
  logic [31:0] E_Data2;
  logic [2:0]  MDOp;
  logic        D_Stall, Done, Err;
  logic [31:0] StallCnt;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining busy cycles, sticky error, stall count.
  int          rem = 0;
  logic        err_m = 1'b0;
  logic [31:0] scnt_m = 32'd0;
  int          done_seen = 0;

  always #5 Clk = ~Clk;

  md_issue_ctrl #(.MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut (
    .Clk(Clk), .Reset(Reset), .E_Valid(E_Valid), .E_Flush(E_Flush), .E_MDOp(E_MDOp),
    .E_Data2(E_Data2), .D_UseMD(D_UseMD), .MDU_Busy(MDU_Busy), .MDOp(MDOp),
    .D_Stall(D_Stall), .Done(Done), .Err(Err), .StallCnt(StallCnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle (inputs just after posedge), check at negedge, advance model at posedge.
  task automatic step(input logic rst, input logic v, input logic fl, input logic [2:0] op,
                      input logic [31:0] d2, input logic use_md, input logic bad,
                      input logic chk);
    int   lat;
    logic issue;
    logic exp_stall;
    Reset = rst; E_Valid = v; E_Flush = fl; E_MDOp = op; E_Data2 = d2; D_UseMD = use_md;
    MDU_Busy = (rem > 0) ^ bad;
    #4;
    lat = 0;
    if (op == 3'd1 || op == 3'd2 || op == 3'd7) lat = MulLat;
    else if ((op == 3'd3 || op == 3'd4) && d2 != 32'd0) lat = DivLat;
    issue = rst && v && !fl && rem == 0;
    exp_stall = rst && use_md && ((issue && lat > 0) || rem > 0);
    if (chk) begin
      check("mdop", {29'd0, MDOp}, issue ? {29'd0, op} : 32'd0);
      check("d_stall", {31'd0, D_Stall}, {31'd0, exp_stall});
      check("done", {31'd0, Done}, {31'd0, (rst && rem == 1)});
      check("err", {31'd0, Err}, {31'd0, err_m});
`ifdef MD_STALL_CNT_EN
      check("stall_cnt", StallCnt, scnt_m);
`else
      check("stall_cnt", StallCnt, 32'd0);
`endif
    end
    if (Done === 1'b1) done_seen++;
    @(posedge Clk);
    if (!rst) begin
      rem = 0; err_m = 1'b0; scnt_m = 32'd0;
    end else begin
      if ((v && op != 3'd0 && rem > 0) || bad) err_m = 1'b1;
      if (exp_stall) scnt_m = scnt_m + 32'd1;
      if (rem > 0) rem = rem - 1;
      else if (issue) rem = lat;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic use_md);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, use_md, 1'b0, 1'b1);
  endtask

  initial begin
    #1;
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'd1, 32'd5, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b0);

    // mult + mfhi: stall t..t+5, Done at t+5.
    done_seen = 0;
    step(1'b1, 1'b1, 1'b0, 3'd1, 32'd3, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);
    check("mult_done_count", done_seen, 1);

    // divu with nonzero divisor: 11 stall cycles.
    step(1'b1, 1'b1, 1'b0, 3'd4, 32'd7, 1'b1, 1'b0, 1'b1);
    idle(11, 1'b1);

    // div by zero: passes through, no window.
    done_seen = 0;
    step(1'b1, 1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);
    check("div0_no_done", done_seen, 0);

    // Flushed mult and mthi/mtlo never open a window.
    step(1'b1, 1'b1, 1'b1, 3'd1, 32'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd5, 32'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd6, 32'd1, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Reset at t+2 of a div.
    step(1'b1, 1'b1, 1'b0, 3'd3, 32'd9, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Three back-to-back mult + mfhi pairs.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 3'd1, 32'd2, 1'b1, 1'b0, 1'b1);
      idle(5, 1'b1);
    end
`ifdef MD_STALL_CNT_EN
    check("stall_cnt_18", StallCnt, 32'd18);
`else
    check("stall_cnt_tied", StallCnt, 32'd0);
`endif

    // Op issued while busy must flag Err and be dropped.
    step(1'b1, 1'b1, 1'b0, 3'd7, 32'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'd1, 1'b0, 1'b0, 1'b1);
    idle(6, 1'b0);
    check("err_sticky", {31'd0, Err}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // MDU busy disagreement.
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        r_rst, r_v, r_fl, r_use, r_bad;
      logic [2:0]  r_op;
      logic [31:0] r_d2;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_v   = (rem > 0) ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 70);
      r_fl  = ($urandom_range(0, 99) < 10);
      r_op  = 3'($urandom_range(0, 7));
      r_d2  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      r_use = $urandom_range(0, 1) == 1;
      r_bad = ($urandom_range(0, 199) == 0);
      step(r_rst, r_v, r_fl, r_op, r_d2, r_use, r_bad, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
